// File: rtl/sound_pkg.sv
// Shared widths, frame constant and state encoding for the audio output path.
package sound_pkg;

  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned COUNT_WIDTH  = 10;

  // Last count of a frame; the cycle on which samples and mode are committed.
  localparam logic [COUNT_WIDTH-1:0] FRAME_END = {COUNT_WIDTH{1'b1}};

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } out_state_e;

endpackage

// File: rtl/delta_sigma_mod.sv
// First-order delta-sigma modulator: the carry of a wrapping accumulator is the output bit.
module delta_sigma_mod
  import sound_pkg::*;
#(
  parameter int unsigned CODE_WIDTH = sound_pkg::SAMPLE_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  clear_in,
  input  logic [CODE_WIDTH-1:0] code_in,
  output logic                  bit_out
);

  logic [CODE_WIDTH:0] acc_q;

  // Carry is dropped each step so it appears exactly once per overflow.
  always_ff @(posedge clk_in) begin
    if (reset_in || clear_in) begin
      acc_q <= '0;
    end else begin
      acc_q <= {1'b0, acc_q[CODE_WIDTH-1:0]} + {1'b0, code_in};
    end
  end

  assign bit_out = acc_q[CODE_WIDTH];

endmodule

// File: rtl/audio_out_stage.sv
// Frame-aligned sample buffering feeding a PWM or delta-sigma 1-bit audio output.
module audio_out_stage #(
  parameter int unsigned SAMPLE_WIDTH = sound_pkg::SAMPLE_WIDTH,
  parameter int unsigned COUNT_WIDTH  = sound_pkg::COUNT_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [COUNT_WIDTH-1:0]  master_count_in,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    data_valid_in,
  input  logic                    mode_in,
  output logic                    audio_out,
  output logic                    sample_strobe_out,
  output logic                    underrun_out,
  output logic                    overrun_out
);

  import sound_pkg::*;

  localparam logic [COUNT_WIDTH-1:0] FRAME_LAST = {COUNT_WIDTH{1'b1}};

  logic [SAMPLE_WIDTH-1:0] pending_q;
  logic                    pending_valid_q;
  logic [SAMPLE_WIDTH-1:0] active_q;
  out_state_e              state_q;
  logic                    mode_q;

  logic                    boundary_c;
  logic                    load_c;
  logic [SAMPLE_WIDTH-1:0] load_data_c;
  logic                    ds_clear_c;
  logic [SAMPLE_WIDTH-1:0] code_c;
  logic [COUNT_WIDTH-1:0]  duty_c;
  logic                    pwm_bit_c;
  logic                    ds_bit;

  assign boundary_c  = (master_count_in == FRAME_LAST);
  assign load_c      = boundary_c && (pending_valid_q || data_valid_in);
  // An empty pending slot lets a sample arriving on the boundary go straight to active.
  assign load_data_c = pending_valid_q ? pending_q : data_in;
  assign ds_clear_c  = boundary_c && (mode_in != mode_q);

  // Offset-binary code: most negative sample maps to 0, most positive to all-ones.
  assign code_c    = {~active_q[SAMPLE_WIDTH-1], active_q[SAMPLE_WIDTH-2:0]};
  assign duty_c    = code_c[SAMPLE_WIDTH-1 -: COUNT_WIDTH];
  assign pwm_bit_c = (master_count_in < duty_c);

  // Sample buffering, frame state machine and status pulses.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pending_q         <= '0;
      pending_valid_q   <= 1'b0;
      active_q          <= '0;
      state_q           <= WAIT_FIRST;
      mode_q            <= 1'b0;
      sample_strobe_out <= 1'b0;
      underrun_out      <= 1'b0;
      overrun_out       <= 1'b0;
    end else begin
      sample_strobe_out <= load_c;
      underrun_out      <= boundary_c && !pending_valid_q && !data_valid_in && (state_q == RUN);
      overrun_out       <= !boundary_c && data_valid_in && pending_valid_q;

      if (load_c) begin
        active_q <= load_data_c;
      end

      case (state_q)
        WAIT_FIRST: if (load_c) state_q <= RUN;
        RUN:        state_q <= RUN;
        default:    state_q <= WAIT_FIRST;
      endcase

      if (boundary_c) begin
        mode_q          <= mode_in;
        pending_valid_q <= pending_valid_q && data_valid_in;
        if (pending_valid_q && data_valid_in) begin
          pending_q <= data_in;
        end
      end else if (data_valid_in) begin
        pending_q       <= data_in;
        pending_valid_q <= 1'b1;
      end
    end
  end

  delta_sigma_mod #(
    .CODE_WIDTH(SAMPLE_WIDTH)
  ) u_delta_sigma (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .clear_in(ds_clear_c),
    .code_in (code_c),
    .bit_out (ds_bit)
  );

  // Output bit selected by the frame-aligned mode.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      audio_out <= 1'b0;
    end else begin
      audio_out <= mode_q ? ds_bit : pwm_bit_c;
    end
  end

endmodule

// File: tb/tb_audio_out_stage.sv
// Frame-level bench for audio_out_stage: per-frame output statistics checked against expectations.
module tb_audio_out_stage;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [9:0]  master_count_in = '0;
  logic [15:0] data_in = '0;
  logic        data_valid_in = 1'b0;
  logic        mode_in = 1'b0;
  logic        audio_out;
  logic        sample_strobe_out;
  logic        underrun_out;
  logic        overrun_out;

  audio_out_stage dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .master_count_in  (master_count_in),
    .data_in          (data_in),
    .data_valid_in    (data_valid_in),
    .mode_in          (mode_in),
    .audio_out        (audio_out),
    .sample_strobe_out(sample_strobe_out),
    .underrun_out     (underrun_out),
    .overrun_out      (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // One frame of stimulus plus the statistics expected over counts 0..1023.
  typedef struct {
    logic        ma;
    logic        mb;
    int          nw;
    logic [15:0] d0;
    int          c0;
    logic [15:0] d1;
    int          c1;
    int          hlo;
    int          hhi;
    int          rlo;
    int          rhi;
    int          stb;
    int          und;
    int          ovr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_out = 1'b0;

  function automatic vec_t mk(input logic ma, input logic mb, input int nw,
                              input logic [15:0] d0, input int c0,
                              input logic [15:0] d1, input int c1,
                              input int hlo, input int hhi, input int rlo, input int rhi,
                              input int stb, input int und, input int ovr);
    vec_t v;
    v.ma = ma; v.mb = mb; v.nw = nw;
    v.d0 = d0; v.c0 = c0; v.d1 = d1; v.c1 = c1;
    v.hlo = hlo; v.hhi = hhi; v.rlo = rlo; v.rhi = rhi;
    v.stb = stb; v.und = und; v.ovr = ovr;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clk_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int   hi_n;
    int   rise_n;
    int   stb_n;
    int   und_n;
    int   ovr_n;
    vec_t e;
    hi_n = 0; rise_n = 0; stb_n = 0; und_n = 0; ovr_n = 0;
    exp_q.push_back(v);
    for (int c = 0; c < 1024; c++) begin
      master_count_in = 10'(c);
      mode_in         = (c < 500) ? v.ma : v.mb;
      data_valid_in   = 1'b0;
      data_in         = '0;
      if (v.nw >= 1 && c == v.c0) begin data_valid_in = 1'b1; data_in = v.d0; end
      if (v.nw >= 2 && c == v.c1) begin data_valid_in = 1'b1; data_in = v.d1; end
      clk_step();
      if (audio_out) hi_n++;
      if (audio_out && !prev_out) rise_n++;
      prev_out = audio_out;
      if (sample_strobe_out) stb_n++;
      if (underrun_out) und_n++;
      if (overrun_out) ovr_n++;
    end
    e = exp_q.pop_front();
    check($sformatf("f%0d_high", idx), hi_n, e.hlo, e.hhi);
    check($sformatf("f%0d_rise", idx), rise_n, e.rlo, e.rhi);
    check($sformatf("f%0d_strobe", idx), stb_n, e.stb, e.stb);
    check($sformatf("f%0d_underrun", idx), und_n, e.und, e.und);
    check($sformatf("f%0d_overrun", idx), ovr_n, e.ovr, e.ovr);
  endtask

  // Reset at count 700 with a pending sample: outputs clear at once, pending is lost.
  task automatic reset_mid_frame();
    int stb_n;
    int und_n;
    stb_n = 0; und_n = 0;
    for (int c = 0; c < 700; c++) begin
      master_count_in = 10'(c);
      mode_in         = 1'b1;
      data_valid_in   = (c == 600);
      data_in         = (c == 600) ? 16'h5555 : 16'h0000;
      clk_step();
    end
    master_count_in = 10'd700;
    data_valid_in   = 1'b0;
    reset_in        = 1'b1;
    clk_step();
    check("rst_mid_audio", int'(audio_out), 0, 0);
    check("rst_mid_strobe", int'(sample_strobe_out), 0, 0);
    check("rst_mid_underrun", int'(underrun_out), 0, 0);
    check("rst_mid_overrun", int'(overrun_out), 0, 0);
    reset_in = 1'b0;
    mode_in  = 1'b0;
    prev_out = audio_out;
    for (int c = 701; c < 1024; c++) begin
      master_count_in = 10'(c);
      clk_step();
      prev_out = audio_out;
      if (sample_strobe_out) stb_n++;
      if (underrun_out) und_n++;
    end
    check("rst_tail_strobe", stb_n, 0, 0);
    check("rst_tail_underrun", und_n, 0, 0);
  endtask

  initial begin
    // Reset-idle frames, PWM extremes, delta-sigma densities, overrun, boundary writes, mode alignment.
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    512,  512,  1,   1,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    512,  512,  1,   1,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    512,  512,  1,   1,   0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h7FFF, 100,  16'h0000, 0,    512,  512,  1,   1,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    1023, 1023, 1,   1,   0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 16'h8000, 10,   16'h0000, 0,    1023, 1023, 1,   1,   1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 16'h0000, 50,   16'h0000, 0,    0,    0,    0,   0,   1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0,    16'h0000, 0,    511,  513,  510, 513, 0, 1, 0));
    vecs.push_back(mk(1, 1, 2, 16'h1234, 10,   16'h4000, 20,   511,  513,  510, 514, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    766,  770,  254, 258, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    768,  768,  0,   1,   0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'hA000, 1023, 16'h0000, 0,    768,  768,  1,   1,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    128,  128,  1,   1,   0, 1, 0));
    vecs.push_back(mk(0, 0, 2, 16'h1111, 500,  16'h7000, 1023, 128,  128,  1,   1,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0,    16'h0000, 0,    580,  580,  1,   1,   1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0000, 10,   16'h0000, 0,    960,  960,  1,   1,   1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0,    16'h0000, 0,    512,  512,  1,   1,   0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0,    16'h0000, 0,    511,  513,  510, 513, 0, 1, 0));

    reset_in = 1'b1;
    for (int i = 0; i < 3; i++) clk_step();
    check("reset_audio", int'(audio_out), 0, 0);
    check("reset_strobe", int'(sample_strobe_out), 0, 0);
    check("reset_underrun", int'(underrun_out), 0, 0);
    check("reset_overrun", int'(overrun_out), 0, 0);
    reset_in = 1'b0;
    prev_out = audio_out;

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i], i);
    end

    reset_mid_frame();
    run_frame(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 512, 512, 1, 1, 0, 0, 0), 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
